// File: rtl/mac_share_arbiter.sv
// ---------------------------------------------------------------------------
// mac_share_arbiter
//   Shares one unsigned add/multiply unit between NREQ requesters. A
//   round-robin arbiter picks one pending request at a time, latches that
//   requester's opcode and operands, runs a single operation and returns the
//   result tagged with the requester index. Only one operation is in flight.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        per-requester request level, held until granted
//   op         per-requester opcode (0 = add, 1 = multiply)
//   opa / opb  packed operands, slice i = opX[i*DW +: DW]
//   gnt        one-hot grant, single-cycle pulse
//   busy       high from the grant cycle through the res_valid cycle
//   res_valid  single-cycle result strobe
//   res_id     index of the requester owning the result
//   result     add: zero-extended DW+1-bit sum; mul: full 2*DW product
//
// Optional build macro
//   MAC_ARB_SVA_EN : compiles in the protocol checker (mac_share_arbiter_sva).
// ---------------------------------------------------------------------------

`ifdef MAC_ARB_SVA_EN
// Protocol checker: grant/result sequencing and starvation bound.
module mac_share_arbiter_sva #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3
) (
  input logic            clk,
  input logic            rst,
  input logic [NREQ-1:0] req,
  input logic [NREQ-1:0] gnt,
  input logic            busy,
  input logic            res_valid,
  input logic            op_lat
);
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
    else $error("gnt not onehot0");
  a_gnt_busy: assert property (@(posedge clk) disable iff (rst) $rose(|gnt) |-> busy)
    else $error("grant without busy");
  a_rv_pulse: assert property (@(posedge clk) disable iff (rst) res_valid |=> !res_valid)
    else $error("res_valid longer than one cycle");
  a_add_lat: assert property (@(posedge clk) disable iff (rst)
    (|gnt && !op_lat) |-> !res_valid ##1 !res_valid ##1 res_valid)
    else $error("add latency wrong");
  a_mul_lat: assert property (@(posedge clk) disable iff (rst)
    (|gnt && op_lat) |-> !res_valid ##1 (!res_valid)[*MUL_LAT] ##1 res_valid)
    else $error("multiply latency wrong");
  a_no_gnt_busy: assert property (@(posedge clk) disable iff (rst) (|gnt) |-> !$past(busy))
    else $error("grant issued while busy");

  for (genvar i = 0; i < NREQ; i++) begin : g_starve
    logic [3:0] wait_r;
    // Count foreign grants while requester i is waiting.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wait_r <= 4'd0;
      end else if (!req[i] || gnt[i]) begin
        wait_r <= 4'd0;
      end else if (|gnt) begin
        wait_r <= wait_r + 4'd1;
      end else begin
        wait_r <= wait_r;
      end
    end
    a_starve: assert property (@(posedge clk) disable iff (rst) wait_r <= 4'(NREQ - 1))
      else $error("requester starved");
  end
endmodule
`endif

module mac_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int MUL_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     op,
  input  logic [NREQ*DW-1:0]  opa,
  input  logic [NREQ*DW-1:0]  opb,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic                res_valid,
  output logic [2:0]          res_id,
  output logic [2*DW-1:0]     result
);
  // Counter must hold MUL_LAT-1.
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       rr_ptr_r;
  logic [2:0]       id_r;
  logic [CW-1:0]    cnt_r;
  logic             op_r;
  logic [DW-1:0]    opa_r;
  logic [DW-1:0]    opb_r;

  logic             win_found_s;
  logic [2:0]       win_idx_s;
  logic [2:0]       next_ptr_s;
  logic [NREQ-1:0]  win_oh_s;
  logic             win_op_s;
  logic [DW-1:0]    win_opa_s;
  logic [DW-1:0]    win_opb_s;
  logic [DW:0]      sum_s;
  logic [2*DW-1:0]  prod_s;
  logic [2*DW-1:0]  exec_res_s;

  // Round-robin search: first set request at or above rr_ptr, wrapping.
  always_comb begin
    logic [3:0] cand_v;
    logic       hit_v;
    win_found_s = 1'b0;
    win_idx_s   = 3'd0;
    cand_v      = 4'd0;
    hit_v       = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand_v = {1'b0, rr_ptr_r} + 4'(off);
      cand_v = (cand_v >= 4'(NREQ)) ? (cand_v - 4'(NREQ)) : cand_v;
      hit_v  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        hit_v = hit_v | (req[i] & (cand_v == 4'(i)));
      end
      win_idx_s   = (!win_found_s && hit_v) ? cand_v[2:0] : win_idx_s;
      win_found_s = win_found_s | hit_v;
    end
  end

  // Winner one-hot, its opcode/operands and the pointer that follows it.
  always_comb begin
    win_oh_s  = {NREQ{1'b0}};
    win_op_s  = 1'b0;
    win_opa_s = {DW{1'b0}};
    win_opb_s = {DW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      win_oh_s[i] = (win_idx_s == 3'(i));
      win_op_s    = (win_idx_s == 3'(i)) ? op[i] : win_op_s;
      win_opa_s   = (win_idx_s == 3'(i)) ? opa[i*DW +: DW] : win_opa_s;
      win_opb_s   = (win_idx_s == 3'(i)) ? opb[i*DW +: DW] : win_opb_s;
    end
    next_ptr_s = (win_idx_s == 3'(NREQ - 1)) ? 3'd0 : (win_idx_s + 3'd1);
  end

  // Shared arithmetic on the latched operands only.
  always_comb begin
    sum_s      = {1'b0, opa_r} + {1'b0, opb_r};
    prod_s     = {{DW{1'b0}}, opa_r} * {{DW{1'b0}}, opb_r};
    exec_res_s = op_r ? prod_s : {{(DW-1){1'b0}}, sum_s};
  end

  // Control FSM with registered outputs. DONE spends one cycle raising
  // res_valid and one cycle dropping it, so the next grant lands L+3 edges
  // after the previous one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      rr_ptr_r  <= 3'd0;
      id_r      <= 3'd0;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 1'b0;
      opa_r     <= {DW{1'b0}};
      opb_r     <= {DW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 3'd0;
      result    <= {(2*DW){1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          res_valid <= 1'b0;
          if (win_found_s) begin
            gnt      <= win_oh_s;
            busy     <= 1'b1;
            id_r     <= win_idx_s;
            op_r     <= win_op_s;
            opa_r    <= win_opa_s;
            opb_r    <= win_opb_s;
            rr_ptr_r <= next_ptr_s;
            cnt_r    <= win_op_s ? CW'(MUL_LAT - 1) : {CW{1'b0}};
            state_r  <= EXEC;
          end else begin
            gnt     <= {NREQ{1'b0}};
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        EXEC: begin
          gnt <= {NREQ{1'b0}};
          if (cnt_r == {CW{1'b0}}) begin
            result  <= exec_res_s;
            res_id  <= id_r;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        DONE: begin
          gnt <= {NREQ{1'b0}};
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          gnt       <= {NREQ{1'b0}};
          busy      <= 1'b0;
          res_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

`ifdef MAC_ARB_SVA_EN
  mac_share_arbiter_sva #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT)
  ) u_sva (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .op_lat    (op_r)
  );
`else
  // Default build carries no checker logic.
`endif

endmodule
